interrupt_controller: RTL

Latches, masks and prioritises the 8 interrupt request lines driven by `timer` and `i_o_manager`, and presents one request at a time to `cpu`. It sits directly between the interrupt sources and the CPU's interrupt input. It provides edge capture, a software-writable enable mask, fixed priority, and a request/acknowledge/return handshake with the CPU. Nesting is not supported.

---
 rtl/interrupt_controller_pkg.sv | 14 +
 rtl/interrupt_controller_priority_encoder.sv | 25 ++
 rtl/interrupt_controller.sv | 124 ++++++++++++
 3 files changed

// File: rtl/interrupt_controller_pkg.sv
// Shared constants for the interrupt controller slice.
//   N_IRQ_DEF / ID_W_DEF : default request-line count and id width
//   ST_*                 : controller FSM state encodings
package interrupt_controller_pkg;

    localparam int unsigned N_IRQ_DEF = 8;
    localparam int unsigned ID_W_DEF  = 3;
    localparam int unsigned ST_W      = 2;

    localparam logic [ST_W-1:0] ST_IDLE    = 2'd0;
    localparam logic [ST_W-1:0] ST_REQ     = 2'd1;
    localparam logic [ST_W-1:0] ST_SERVICE = 2'd2;

endpackage : interrupt_controller_pkg

// File: rtl/interrupt_controller_priority_encoder.sv
// Fixed-priority encoder: lowest set bit index wins.
//   req_vec : N_IRQ-bit request vector (in)
//   idx     : index of the lowest set bit, 0 when none set (out)
//   any     : at least one bit set (out)
module irq_priority_encoder #(
    parameter int unsigned N_IRQ = 8,
    parameter int unsigned ID_W  = 3
) (
    input  logic [N_IRQ-1:0] req_vec,
    output logic [ID_W-1:0]  idx,
    output logic             any
);

    // Scan from the top down so the lowest set index is written last.
    always_comb begin
        idx = '0;
        any = |req_vec;
        for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                idx = ID_W'(i);
            end
        end
    end

endmodule : irq_priority_encoder

// File: rtl/interrupt_controller.sv
// Interrupt controller: edge capture, enable mask, fixed priority and a
// request/ack/return handshake with the CPU (no nesting).
//   clk, reset           : clock, synchronous active-high reset
//   irq_in               : raw request lines
//   mask_we, mask_wdata  : enable-mask write port
//   irq_ack, irq_ret     : CPU handshake pulses
//   irq_req, irq_id      : presented request and its index
//   pending, mask        : latched pending bits and current mask
//   in_service           : CPU is inside an interrupt routine
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int unsigned      N_IRQ      = N_IRQ_DEF,
    parameter int unsigned      ID_W       = ID_W_DEF,
    parameter logic [N_IRQ-1:0] MASK_RESET = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_wdata,
    input  logic             irq_ack,
    input  logic             irq_ret,
    output logic             irq_req,
    output logic [ID_W-1:0]  irq_id,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] mask,
    output logic             in_service
);

    logic [ST_W-1:0]  state_q, state_d;
    logic [N_IRQ-1:0] irq_prev_q, irq_prev_d;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] mask_q, mask_d;
    logic [ID_W-1:0]  irq_id_q, irq_id_d;
    logic             irq_req_q, irq_req_d;
    logic             in_service_q, in_service_d;

    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] eligible;
    logic [N_IRQ-1:0] clr;
    logic [ID_W-1:0]  enc_id;
    logic             enc_any;

    assign rise     = irq_in & ~irq_prev_q;
    assign eligible = pending_q & mask_q;

    irq_priority_encoder #(
        .N_IRQ (N_IRQ),
        .ID_W  (ID_W)
    ) u_prio (
        .req_vec (eligible),
        .idx     (enc_id),
        .any     (enc_any)
    );

    // Next-state, pending update and registered-output decode.
    always_comb begin
        state_d    = state_q;
        irq_id_d   = irq_id_q;
        irq_prev_d = irq_in;
        mask_d     = mask_we ? mask_wdata : mask_q;
        clr        = '0;

        case (state_q)
            ST_IDLE: begin
                if (enc_any) begin
                    state_d  = ST_REQ;
                    irq_id_d = enc_id;
                end
            end
            ST_REQ: begin
                if (irq_ack) begin
                    clr     = N_IRQ'(1) << irq_id_q;
                    state_d = ST_SERVICE;
                end else if (!eligible[irq_id_q]) begin
                    // Latched line was masked: withdraw the request.
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (irq_ret) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new edge overrides a same-cycle ack clear so it is not lost.
        pending_d    = (pending_q & ~clr) | rise;
        irq_req_d    = (state_d == ST_REQ);
        in_service_d = (state_d == ST_SERVICE);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            irq_prev_q   <= '0;
            pending_q    <= '0;
            mask_q       <= MASK_RESET;
            irq_id_q     <= '0;
            irq_req_q    <= 1'b0;
            in_service_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            irq_prev_q   <= irq_prev_d;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            irq_id_q     <= irq_id_d;
            irq_req_q    <= irq_req_d;
            in_service_q <= in_service_d;
        end
    end

    assign irq_req    = irq_req_q;
    assign irq_id     = irq_id_q;
    assign pending    = pending_q;
    assign mask       = mask_q;
    assign in_service = in_service_q;

endmodule : interrupt_controller
